// File: rtl/huffman_decode.sv
// Bit-serial Huffman decoder: matches an MSB-first bitstream against a packed
// {len, code} table and emits one symbol index per matched codeword.
module huffman_decode #(
  parameter int unsigned SYMW   = 4,
  parameter int unsigned NSYM   = 16,
  parameter int unsigned MAXLEN = 15,
  parameter int unsigned LENW   = 4,
  parameter int unsigned CNTW   = 16
) (
  input  logic                            CLK,
  input  logic                            nRST,
  input  logic                            start,
  input  logic [NSYM*(LENW+MAXLEN)-1:0]   TABLE_IN,
  input  logic [CNTW-1:0]                 TOTAL_BITS,
  input  logic                            BIT_IN,
  input  logic                            bit_valid,
  output logic                            bit_ready,
  output logic [SYMW-1:0]                 SYMBOL_OUT,
  output logic                            sym_valid,
  input  logic                            sym_ready,
  output logic                            decode_over,
  output logic                            decode_err
);

  localparam int unsigned EW = LENW + MAXLEN;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EMIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t                     state;
  logic [NSYM*EW-1:0]         tbl;
  logic [CNTW-1:0]            total;
  logic [MAXLEN-1:0]          acc;
  logic [LENW-1:0]            cur_len;
  logic [CNTW-1:0]            bits_used;

  logic [MAXLEN-1:0]          nacc;
  logic [LENW-1:0]            nlen;
  logic [MAXLEN-1:0]          mask;
  logic                       match;
  logic [SYMW-1:0]            match_idx;

  assign nacc = {acc[MAXLEN-2:0], BIT_IN};
  assign nlen = cur_len + LENW'(1);
  assign mask = ~({MAXLEN{1'b1}} << nlen);

  // First hit in ascending index order, so the lowest index wins on duplicates.
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    for (int unsigned i = 0; i < NSYM; i++) begin
      if (!match && (tbl[i*EW+MAXLEN +: LENW] == nlen) &&
          (((tbl[i*EW +: MAXLEN] ^ nacc) & mask) == '0)) begin
        match     = 1'b1;
        match_idx = SYMW'(i);
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= S_IDLE;
      tbl         <= '0;
      total       <= '0;
      acc         <= '0;
      cur_len     <= '0;
      bits_used   <= '0;
      bit_ready   <= 1'b0;
      SYMBOL_OUT  <= '0;
      sym_valid   <= 1'b0;
      decode_over <= 1'b0;
      decode_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            tbl        <= TABLE_IN;
            total      <= TOTAL_BITS;
            acc        <= '0;
            cur_len    <= '0;
            bits_used  <= '0;
            SYMBOL_OUT <= '0;
            sym_valid  <= 1'b0;
            decode_err <= 1'b0;
            if (TOTAL_BITS == '0) begin
              state       <= S_DONE;
              decode_over <= 1'b1;
              bit_ready   <= 1'b0;
            end else begin
              state       <= S_DECODE;
              decode_over <= 1'b0;
              bit_ready   <= 1'b1;
            end
          end
        end
        S_DECODE: begin
          if (bit_valid && bit_ready) begin
            bits_used <= bits_used + CNTW'(1);
            if (match) begin
              SYMBOL_OUT <= match_idx;
              sym_valid  <= 1'b1;
              bit_ready  <= 1'b0;
              acc        <= '0;
              cur_len    <= '0;
              state      <= S_EMIT;
            end else if ((nlen == LENW'(MAXLEN)) ||
                         (bits_used + CNTW'(1) == total)) begin
              decode_err <= 1'b1;
              bit_ready  <= 1'b0;
              state      <= S_ERR;
            end else begin
              acc     <= nacc;
              cur_len <= nlen;
            end
          end
        end
        S_EMIT: begin
          if (sym_ready) begin
            sym_valid <= 1'b0;
            if (bits_used == total) begin
              decode_over <= 1'b1;
              state       <= S_DONE;
            end else begin
              bit_ready <= 1'b1;
              state     <= S_DECODE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_huffman_decode.sv
// Directed self-checking bench for huffman_decode using a small prefix code table.
module tb_huffman_decode;

  localparam int unsigned SYMW   = 4;
  localparam int unsigned NSYM   = 16;
  localparam int unsigned MAXLEN = 15;
  localparam int unsigned LENW   = 4;
  localparam int unsigned CNTW   = 16;
  localparam int unsigned EW     = LENW + MAXLEN;

  logic                    CLK = 1'b0;
  logic                    nRST;
  logic                    start;
  logic [NSYM*EW-1:0]      TABLE_IN;
  logic [CNTW-1:0]         TOTAL_BITS;
  logic                    BIT_IN;
  logic                    bit_valid;
  logic                    bit_ready;
  logic [SYMW-1:0]         SYMBOL_OUT;
  logic                    sym_valid;
  logic                    sym_ready;
  logic                    decode_over;
  logic                    decode_err;

  huffman_decode #(
    .SYMW(SYMW), .NSYM(NSYM), .MAXLEN(MAXLEN), .LENW(LENW), .CNTW(CNTW)
  ) dut (
    .CLK(CLK), .nRST(nRST), .start(start), .TABLE_IN(TABLE_IN),
    .TOTAL_BITS(TOTAL_BITS), .BIT_IN(BIT_IN), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .SYMBOL_OUT(SYMBOL_OUT), .sym_valid(sym_valid),
    .sym_ready(sym_ready), .decode_over(decode_over), .decode_err(decode_err)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  logic [NSYM*EW-1:0] tbl_full;
  logic [NSYM*EW-1:0] tbl_small;
  logic               bitq [0:63];

  // Results gathered by run_stream for the calling test to judge.
  logic [SYMW-1:0]    got[$];
  int                 consumed;
  int                 cycles;
  int                 hold_bad;
  int                 timed_out;

  task automatic load_bits(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) bitq[i] = v[n-1-i];
  endtask

  // Pulses start; returns at the negedge after the start edge.
  task automatic do_start(input logic [NSYM*EW-1:0] t, input logic [CNTW-1:0] tot);
    @(negedge CLK);
    TABLE_IN   = t;
    TOTAL_BITS = tot;
    start      = 1'b1;
    @(negedge CLK);
    start      = 1'b0;
  endtask

  // Feeds n bits with bit_valid held high, stalls sym_ready per symbol, stops on over/err.
  task automatic run_stream(input int n, input int stall, input int budget);
    int idx, wait_cnt;
    logic take;
    logic [SYMW-1:0] held;
    got.delete();
    idx = 0; wait_cnt = 0; cycles = 0; hold_bad = 0; timed_out = 0; held = '0;
    sym_ready = (stall == 0);
    forever begin
      if (decode_over || decode_err) break;
      if (cycles >= budget) begin timed_out = 1; break; end
      if (sym_valid) begin
        if (wait_cnt == 0) held = SYMBOL_OUT;
        if (SYMBOL_OUT !== held || bit_ready !== 1'b0) hold_bad++;
        if (wait_cnt < stall) begin
          sym_ready = 1'b0;
          wait_cnt++;
        end else begin
          sym_ready = 1'b1;
          got.push_back(SYMBOL_OUT);
          wait_cnt = 0;
        end
      end else begin
        sym_ready = (stall == 0);
      end
      take = 1'b0;
      if (idx < n) begin
        bit_valid = 1'b1;
        BIT_IN    = bitq[idx];
        take      = bit_ready;
      end else begin
        bit_valid = 1'b0;
      end
      @(posedge CLK);
      if (take) idx++;
      cycles++;
      @(negedge CLK);
    end
    consumed  = idx;
    bit_valid = 1'b0;
    sym_ready = 1'b0;
  endtask

  task automatic test_reset();
    nRST = 1'b0; start = 1'b0; TABLE_IN = '0; TOTAL_BITS = '0;
    BIT_IN = 1'b0; bit_valid = 1'b0; sym_ready = 1'b0;
    repeat (2) @(negedge CLK);
    n_cmp++;
    if ({bit_ready, sym_valid, SYMBOL_OUT, decode_over, decode_err} !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_outputs got=%h want=00",
               {bit_ready, sym_valid, SYMBOL_OUT, decode_over, decode_err});
    end
    nRST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic check_full_sequence(input string tag);
    n_cmp++;
    if (got.size() !== 5) begin
      n_bad++;
      $display("FAIL %s_count got=%0d want=5", tag, got.size());
    end
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== SYMW'(i + 1)) begin
        n_bad++;
        $display("FAIL %s_sym%0d got=%0d want=%0d", tag, i, got[i], i + 1);
      end
    end
  endtask

  task automatic test_stream();
    load_bits(64'b0_10_110_1110_1111, 14);
    do_start(tbl_full, 16'd14);
    run_stream(14, 0, 200);
    check_full_sequence("t1");
    n_cmp++;
    if ({decode_over, decode_err} !== 2'b10 || timed_out != 0) begin
      n_bad++;
      $display("FAIL t1_flags got over/err=%b%b timeout=%0d want=10 0",
               decode_over, decode_err, timed_out);
    end
    n_cmp++;
    if (consumed != 14) begin
      n_bad++;
      $display("FAIL t1_consumed got=%0d want=14", consumed);
    end
    // 14 bits plus one emit cycle for each of the 5 symbols.
    n_cmp++;
    if (cycles != 19) begin
      n_bad++;
      $display("FAIL t1_cycles got=%0d want=19", cycles);
    end
  endtask

  task automatic test_back_to_back();
    load_bits(64'b0_10_110_1110_1111, 14);
    do_start(tbl_full, 16'd14);
    run_stream(14, 5, 400);
    check_full_sequence("t2");
    n_cmp++;
    if (hold_bad != 0) begin
      n_bad++;
      $display("FAIL t2_hold got=%0d violations want=0", hold_bad);
    end
    n_cmp++;
    if ({decode_over, decode_err} !== 2'b10 || consumed != 14) begin
      n_bad++;
      $display("FAIL t2_end got over/err=%b%b consumed=%0d want=10 14",
               decode_over, decode_err, consumed);
    end
    n_cmp++;
    if (cycles != 14 + 5 * 6) begin
      n_bad++;
      $display("FAIL t2_cycles got=%0d want=%0d", cycles, 14 + 5 * 6);
    end
  endtask

  task automatic test_truncated();
    load_bits(64'b11, 2);
    do_start(tbl_full, 16'd2);
    run_stream(2, 0, 50);
    n_cmp++;
    if (got.size() != 0 || consumed != 2) begin
      n_bad++;
      $display("FAIL t3_syms got syms=%0d consumed=%0d want=0 2", got.size(), consumed);
    end
    n_cmp++;
    if ({decode_err, decode_over, bit_ready} !== 3'b100) begin
      n_bad++;
      $display("FAIL t3_err got err/over/ready=%b want=100",
               {decode_err, decode_over, bit_ready});
    end
    n_cmp++;
    if (cycles != 2) begin
      n_bad++;
      $display("FAIL t3_cycles got=%0d want=2", cycles);
    end
  endtask

  task automatic test_maxlen();
    load_bits(64'hFFFFF, 20);
    do_start(tbl_small, 16'd20);
    run_stream(20, 0, 60);
    n_cmp++;
    if (consumed != 15 || got.size() != 0) begin
      n_bad++;
      $display("FAIL t4_consumed got=%0d syms=%0d want=15 0", consumed, got.size());
    end
    n_cmp++;
    if ({decode_err, decode_over, bit_ready} !== 3'b100) begin
      n_bad++;
      $display("FAIL t4_err got err/over/ready=%b want=100",
               {decode_err, decode_over, bit_ready});
    end
  endtask

  task automatic test_zero_bits();
    do_start(tbl_full, 16'd0);
    n_cmp++;
    if ({decode_over, decode_err, bit_ready, sym_valid} !== 4'b1000) begin
      n_bad++;
      $display("FAIL t5_over got over/err/ready/valid=%b want=1000",
               {decode_over, decode_err, bit_ready, sym_valid});
    end
    bit_valid = 1'b1; BIT_IN = 1'b0;
    repeat (2) @(negedge CLK);
    bit_valid = 1'b0;
    n_cmp++;
    if ({decode_over, bit_ready, sym_valid} !== 3'b100) begin
      n_bad++;
      $display("FAIL t5_idle got over/ready/valid=%b want=100",
               {decode_over, bit_ready, sym_valid});
    end
  endtask

  task automatic test_reset_abort();
    do_start(tbl_full, 16'd14);
    bit_valid = 1'b1; BIT_IN = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    bit_valid = 1'b0;
    #1 nRST = 1'b0;
    #1;
    n_cmp++;
    if ({bit_ready, sym_valid, SYMBOL_OUT, decode_over, decode_err} !== 8'h00) begin
      n_bad++;
      $display("FAIL t6_abort got=%h want=00",
               {bit_ready, sym_valid, SYMBOL_OUT, decode_over, decode_err});
    end
    @(negedge CLK);
    nRST = 1'b1;
    do_start(tbl_full, 16'd1);
    BIT_IN = 1'b0; bit_valid = 1'b1; sym_ready = 1'b0;
    @(negedge CLK);
    bit_valid = 1'b0;
    n_cmp++;
    if ({sym_valid, SYMBOL_OUT, bit_ready} !== {1'b1, 4'd1, 1'b0}) begin
      n_bad++;
      $display("FAIL t6_symbol got valid=%b sym=%0d ready=%b want 1 1 0",
               sym_valid, SYMBOL_OUT, bit_ready);
    end
    sym_ready = 1'b1;
    @(negedge CLK);
    sym_ready = 1'b0;
    n_cmp++;
    if ({decode_over, decode_err, sym_valid} !== 3'b100) begin
      n_bad++;
      $display("FAIL t6_over got over/err/valid=%b want=100",
               {decode_over, decode_err, sym_valid});
    end
  endtask

  initial begin
    tbl_full = '0;
    tbl_full[1*EW +: EW] = {4'd1, 15'b0};
    tbl_full[2*EW +: EW] = {4'd2, 15'b10};
    tbl_full[3*EW +: EW] = {4'd3, 15'b110};
    tbl_full[4*EW +: EW] = {4'd4, 15'b1110};
    tbl_full[5*EW +: EW] = {4'd4, 15'b1111};
    tbl_small = '0;
    tbl_small[1*EW +: EW] = {4'd1, 15'b0};
    tbl_small[2*EW +: EW] = {4'd2, 15'b10};

    test_reset();
    test_stream();
    test_back_to_back();
    test_truncated();
    test_maxlen();
    test_zero_bits();
    test_reset_abort();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
